// File: rtl/ibex_multdiv_req_ctrl_if.sv
// Signal bundle between the M-extension issue stage, the request controller and the
// slow multiply/divide unit.
interface ibex_multdiv_req_ctrl_if #(
  parameter int TAG_W = 5
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high. A producer holds valid and its payload until that edge, and valid never
  // waits for ready. The unit side has no ready: md_valid is a one-cycle result strobe.
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             flush;

  logic             md_mult_en;
  logic             md_div_en;
  logic [1:0]       md_operator;
  logic [1:0]       md_signed_mode;
  logic [31:0]      md_op_a;
  logic [31:0]      md_op_b;
  logic             md_valid;
  logic [31:0]      md_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  logic             busy;
  logic [1:0]       dbg_state;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, flush,
    input  md_valid, md_result, rsp_ready,
    output req_ready, md_mult_en, md_div_en, md_operator, md_signed_mode,
    output md_op_a, md_op_b, rsp_valid, rsp_result, rsp_tag, rsp_err,
    output busy, dbg_state
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, flush,
    output md_valid, md_result, rsp_ready,
    input  req_ready, md_mult_en, md_div_en, md_operator, md_signed_mode,
    input  md_op_a, md_op_b, rsp_valid, rsp_result, rsp_tag, rsp_err,
    input  busy, dbg_state
  );
endinterface

// File: rtl/ibex_multdiv_req_ctrl.sv
// Issue/response controller for the slow multiply/divide unit: registers one request,
// holds the unit inputs stable until it answers, and returns the tagged result.
module ibex_multdiv_req_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TAG_W          = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  ibex_multdiv_req_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [31:0]      a_q, a_d, b_q, b_d, result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [1:0]       operator_q, operator_d, signed_q, signed_d;
  logic             is_div_q, is_div_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mult_en_q, div_en_q, rsp_valid_q, busy_q;
  logic             req_ready, accept;
  logic [3:0]       decoded;

  // {operator, signed_mode}; signed_mode bit0 = A signed, bit1 = B signed
  always_comb begin
    decoded = 4'b0000;
    case (bus.req_op)
      3'd0: decoded = 4'b0000;
      3'd1: decoded = 4'b0111;
      3'd2: decoded = 4'b0101;
      3'd3: decoded = 4'b0100;
      3'd4: decoded = 4'b1011;
      3'd5: decoded = 4'b1000;
      3'd6: decoded = 4'b1111;
      3'd7: decoded = 4'b1100;
      default: decoded = 4'b0000;
    endcase
  end

  assign req_ready = !bus.flush && (state_q == IDLE || (state_q == RESP && bus.rsp_ready));
  assign accept    = bus.req_valid && req_ready;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    tag_d      = tag_q;
    operator_d = operator_q;
    signed_d   = signed_q;
    is_div_d   = is_div_q;
    result_d   = result_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ISSUE: begin
          cnt_d = cnt_q + CNT_W'(1);
          // A result arriving on the last allowed cycle beats the timeout.
          if (bus.md_valid) begin
            result_d = bus.md_result;
            err_d    = 1'b0;
            state_d  = RESP;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            result_d = 32'h0;
            err_d    = 1'b1;
            state_d  = RESP;
          end
        end
        RESP:    if (bus.rsp_ready) state_d = IDLE;
        default: state_d = state_q;
      endcase
      // Accept from RESP retires the old response on the same edge.
      if (accept) begin
        a_d        = bus.req_a;
        b_d        = bus.req_b;
        tag_d      = bus.req_tag;
        operator_d = decoded[3:2];
        signed_d   = decoded[1:0];
        is_div_d   = bus.req_op[2];
        cnt_d      = '0;
        state_d    = ISSUE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      operator_q  <= '0;
      signed_q    <= '0;
      is_div_q    <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      mult_en_q   <= 1'b0;
      div_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      operator_q  <= operator_d;
      signed_q    <= signed_d;
      is_div_q    <= is_div_d;
      result_q    <= result_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      mult_en_q   <= (state_d == ISSUE) && !is_div_d;
      div_en_q    <= (state_d == ISSUE) && is_div_d;
      rsp_valid_q <= (state_d == RESP);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.req_ready      = req_ready;
  assign bus.md_mult_en     = mult_en_q;
  assign bus.md_div_en      = div_en_q;
  assign bus.md_operator    = operator_q;
  assign bus.md_signed_mode = signed_q;
  assign bus.md_op_a        = a_q;
  assign bus.md_op_b        = b_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_result     = result_q;
  assign bus.rsp_tag        = tag_q;
  assign bus.rsp_err        = err_q;
  assign bus.busy           = busy_q;
  assign bus.dbg_state      = state_q;
endmodule

// File: tb/tb_ibex_multdiv_req_ctrl.sv
// Self-checking bench for ibex_multdiv_req_ctrl against a table/queue reference model.
module tb_ibex_multdiv_req_ctrl;
  localparam int TO    = 40;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ibex_multdiv_req_ctrl_if #(.TAG_W(TAG_W)) bus ();
  ibex_multdiv_req_ctrl #(.TIMEOUT_CYCLES(TO), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Reference decode, straight from the operation table
  logic [1:0] op_tab  [0:7] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
  logic [1:0] sgn_tab [0:7] = '{2'd0, 2'd3, 2'd1, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0};

  logic [TAG_W+32:0] exp_q[$];   // {err, tag, result}
  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0]       cur_op;
  logic [31:0]      cur_a, cur_b;
  logic [TAG_W-1:0] cur_tag;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
    #1;
    n_tests++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL req_ready_idle got=%b exp=1", bus.req_ready);
    end
    step();
    bus.req_valid = 1'b0; bus.req_op = 3'($urandom); bus.req_a = $urandom; bus.req_b = $urandom;
    cur_op = op; cur_a = a; cur_b = b; cur_tag = tag;
  endtask

  // Unit answers on ISSUE cycle lat (1-based); lat beyond TO means it never answers.
  task automatic issue_phase(input int lat, input logic [31:0] res);
    logic [71:0] obs, exp;
    int n;
    n = (lat < TO) ? lat : TO;
    for (int k = 1; k <= n; k++) begin
      obs = {bus.md_mult_en, bus.md_div_en, bus.md_operator, bus.md_signed_mode,
             bus.md_op_a, bus.md_op_b, bus.rsp_valid, bus.busy};
      exp = {cur_op < 3'd4, cur_op >= 3'd4, op_tab[cur_op], sgn_tab[cur_op],
             cur_a, cur_b, 1'b0, 1'b1};
      n_tests++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL issue k=%0d op=%0d got=%h exp=%h", k, cur_op, obs, exp);
      end
      if (k == lat) begin bus.md_valid = 1'b1; bus.md_result = res; end
      step();
      bus.md_valid = 1'b0; bus.md_result = $urandom;
    end
    if (lat <= TO) exp_q.push_back({1'b0, cur_tag, res});
    else           exp_q.push_back({1'b1, cur_tag, 32'h0});
  endtask

  task automatic resp_phase(input int stall, input bit retire);
    logic [TAG_W+32:0] e;
    logic [TAG_W+36:0] obs, exp;
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++; $display("FAIL resp_queue got=empty exp=entry");
      return;
    end
    e = exp_q.pop_front();
    for (int k = 0; k <= stall; k++) begin
      obs = {bus.rsp_valid, bus.md_mult_en, bus.md_div_en, bus.busy,
             bus.rsp_err, bus.rsp_tag, bus.rsp_result};
      exp = {4'b1001, e};
      n_tests++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL resp k=%0d got=%h exp=%h", k, obs, exp);
      end
      if (k < stall) begin
        bus.rsp_ready = 1'b0; bus.md_valid = 1'($urandom_range(0, 1)); bus.md_result = $urandom;
        step();
      end
    end
    bus.md_valid = 1'b0;
    if (retire) begin
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      #1;
      n_tests++;
      if ({bus.rsp_valid, bus.busy, bus.req_ready} !== 3'b001) begin
        n_fail++;
        $display("FAIL retire got=%b exp=001", {bus.rsp_valid, bus.busy, bus.req_ready});
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    logic [113:0] obs;
    obs = {bus.md_mult_en, bus.md_div_en, bus.md_operator, bus.md_signed_mode, bus.md_op_a,
           bus.md_op_b, bus.rsp_valid, bus.rsp_result, bus.rsp_tag, bus.rsp_err, bus.busy};
    n_tests++;
    if (obs !== '0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s got=%h ready=%b exp=0 ready=1", name, obs, bus.req_ready);
    end
  endtask

  task automatic test_reset();
    step(); step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();
  endtask

  task automatic test_mul();
    send_req(3'd0, 32'd7, 32'd6, 5'd3);
    issue_phase(34, 32'd42);
    resp_phase(0, 1'b1);
  endtask

  task automatic test_mulhsu();
    send_req(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd17);
    issue_phase($urandom_range(1, 10), 32'hFFFF_FFFF);
    resp_phase(1, 1'b1);
  endtask

  task automatic test_back_to_back();
    send_req(3'd7, 32'd100, 32'd7, 5'd9);
    issue_phase(4, 32'd2);
    resp_phase(5, 1'b0);
    bus.req_valid = 1'b1; bus.req_op = 3'd4; bus.req_a = 32'hFFFF_FFF0; bus.req_b = 32'd4;
    bus.req_tag = 5'd21; bus.rsp_ready = 1'b0;
    #1;
    n_tests++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_wait got=%b exp=0", bus.req_ready);
    end
    bus.rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready got=%b exp=1", bus.req_ready);
    end
    step();
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
    cur_op = 3'd4; cur_a = 32'hFFFF_FFF0; cur_b = 32'd4; cur_tag = 5'd21;
    issue_phase(3, 32'hFFFF_FFFC);
    resp_phase(0, 1'b1);
  endtask

  task automatic test_timeout();
    send_req(3'd4, 32'd50, 32'd5, 5'd11);
    issue_phase(TO + 5, 32'd0);
    n_tests++;
    if (bus.md_div_en !== 1'b0) begin
      n_fail++; $display("FAIL timeout_en_drop got=%b exp=0", bus.md_div_en);
    end
    resp_phase(2, 1'b1);
    send_req(3'd4, 32'd50, 32'd5, 5'd12);
    issue_phase(TO, 32'd10);
    resp_phase(0, 1'b1);
  endtask

  task automatic test_flush();
    send_req(3'd1, 32'h1234, 32'h5678, 5'd5);
    for (int k = 1; k <= 2; k++) step();
    bus.flush = 1'b1; bus.md_valid = 1'b1; bus.md_result = 32'hDEAD_BEEF;
    step();
    bus.flush = 1'b0; bus.md_valid = 1'b0;
    n_tests++;
    if ({bus.busy, bus.md_mult_en, bus.md_div_en, bus.rsp_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL flush_idle got=%b exp=0000", {bus.busy, bus.md_mult_en, bus.md_div_en, bus.rsp_valid});
    end
    bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_op = 3'd5;
    #1;
    n_tests++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_block got=%b exp=0", bus.req_ready);
    end
    step();
    bus.flush = 1'b0; bus.req_valid = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_no_accept got=%b exp=0", bus.busy);
    end
    send_req(3'd5, 32'd99, 32'd10, 5'd6);
    issue_phase(2, 32'd9);
    resp_phase(0, 1'b1);
  endtask

  task automatic test_reset_in_resp();
    send_req(3'd3, 32'hAAAA_0000, 32'h0000_5555, 5'd30);
    issue_phase(3, 32'h1111_2222);
    rst = 1'b1;
    step();
    void'(exp_q.pop_front());
    check_reset_outputs("reset_in_resp");
    rst = 1'b0;
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      send_req(3'($urandom), $urandom, $urandom, TAG_W'($urandom));
      issue_phase($urandom_range(1, TO + 4), $urandom);
      resp_phase($urandom_range(0, 3), 1'b1);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
    bus.flush = 1'b0; bus.md_valid = 1'b0; bus.md_result = '0; bus.rsp_ready = 1'b0;
    test_reset();
    test_mul();
    test_mulhsu();
    test_back_to_back();
    test_timeout();
    test_flush();
    test_reset_in_resp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ibex_multdiv_req_ctrl.md
Name: ibex_multdiv_req_ctrl

Overview:
- Issue/response controller directly upstream of the slow multiply/divide unit.
- Accepts one decoded M-extension request over a valid/ready handshake and registers its operands.
- Drives the unit's enable, operator, signed-mode and operand inputs, holding them stable until the unit reports valid.
- Returns the result with its destination tag over a second valid/ready handshake; provides flush and a watchdog timeout.

Parameters:
- TIMEOUT_CYCLES, 64: maximum ISSUE cycles before an error response; must be ≥ 2.
- TAG_W, 5: width of the destination tag (register address).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- req_op_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- req_a_i  in  32  operand A.
- req_b_i  in  32  operand B.
- req_tag_i  in  TAG_W  destination tag.
- flush_i  in  1  abort in-flight operation.
- md_mult_en_o  out  1  multiply enable to the unit.
- md_div_en_o  out  1  divide enable to the unit.
- md_operator_o  out  2  0 MULL, 1 MULH, 2 DIV, 3 REM.
- md_signed_mode_o  out  2  bit0 = A signed, bit1 = B signed.
- md_op_a_o  out  32  registered operand A.
- md_op_b_o  out  32  registered operand B.
- md_valid_i  in  1  unit result valid.
- md_result_i  in  32  unit result.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed.
- rsp_result_o  out  32  result; 0 on error.
- rsp_tag_o  out  TAG_W  tag of the request.
- rsp_err_o  out  1  timeout error flag.
- busy_o  out  1  high when state is not IDLE.

Behaviour:
- States: IDLE, ISSUE, RESP.
- Reset (rst_i high at a clock edge): state IDLE.
  - Deasserted: all enables, rsp_valid_o, rsp_err_o, busy_o.
  - Cleared to 0: md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o, rsp_result_o, rsp_tag_o, timeout counter.
  - Reset mid-operation drops the operation silently.
- req_ready_o = !flush_i && (IDLE || (RESP && rsp_ready_i)). Combinational; no dependence on req_valid_i.
- Accept (req_valid_i && req_ready_o):
  - Register A, B, tag and decoded operator/signed mode.
  - Next state ISSUE; timeout counter cleared.
  - Accept from RESP is back-to-back: the old response retires on the same edge.
- Decode (req_op_i → operator, signed mode):
  - MUL → 0, 00
  - MULH → 1, 11
  - MULHSU → 1, 01
  - MULHU → 1, 00
  - DIV → 2, 11
  - DIVU → 2, 00
  - REM → 3, 11
  - REMU → 3, 00
- ISSUE:
  - md_mult_en_o = op < 4; md_div_en_o = op ≥ 4; exactly one is high.
  - Operands, operator and signed mode are stable for the whole state.
  - Counter increments each ISSUE cycle.
- md_valid_i is sampled only in ISSUE and ignored elsewhere.
  - On md_valid_i: capture md_result_i, rsp_err_o = 0, next state RESP. Enables drop the following cycle.
- Timeout: counter == TIMEOUT_CYCLES-1 with md_valid_i low → RESP with rsp_result_o = 0, rsp_err_o = 1.
  - md_valid_i on the timeout cycle wins: normal response.
- Latency: accept at edge N → enables high from cycle N+1. md_valid_i at cycle M → rsp_valid_o high from cycle M+1.
- RESP: rsp_valid_o held with result/tag/err stable until rsp_ready_i.
  - rsp_ready_i without a new request → IDLE.
- flush_i has highest priority below reset: next state IDLE, and enables and rsp_valid_o are low the following cycle.
  - An md_valid_i in the same cycle as flush_i is discarded.
  - A request presented with flush_i is not accepted.
- Outputs are registered except req_ready_o.

Test Plan:
- MUL A=7, B=6, tag 3; unit returns 42 after 34 cycles → md_mult_en_o=1, md_operator_o=0, md_signed_mode_o=00 for 34 cycles; then rsp_valid_o with result 42, tag 3, err 0.
- MULHSU A=0xFFFFFFFF, B=2; md_valid_i result 0xFFFFFFFF → md_operator_o=1, md_signed_mode_o=01, md_op_a_o=0xFFFFFFFF; response forwards 0xFFFFFFFF.
- REMU, rsp_ready_i low 5 cycles after the result → rsp_valid_o/result/tag held stable for 5 cycles. A second DIV request waits with req_ready_o=0 and is accepted on the rsp_ready_i cycle; div enable rises the next cycle.
- TIMEOUT_CYCLES=8, DIV, md_valid_i never asserted → exactly 8 enable cycles; then rsp_err_o=1, rsp_result_o=0. Repeat with md_valid_i on the 8th cycle → err 0, unit result returned.
- flush_i on ISSUE cycle 3 together with md_valid_i → no response. IDLE and enables low the next cycle; a new request is accepted the cycle after flush deasserts.
- rst_i asserted while in RESP → all outputs return to reset values at the next edge; busy_o=0, req_ready_o=1.
